// File: rtl/dpt_sequencer.sv
// rtl/dpt_sequencer.sv - double-pulse test sequencer with debounced trigger, voltage window and fault abort
// Optional third pulse (GAP2/PULSE3) when DPT_TRIPLE_PULSE_EN is defined.
module dpt_sequencer #(
  parameter int NCH = 4,
  parameter int VOLT_W = 16,
  parameter logic [VOLT_W-1:0] V_LO = 16'h08B0,
  parameter logic [VOLT_W-1:0] V_HI = 16'h0C0C,
  parameter int DEB_CYC = 1_000_000,
  parameter int ARM_DLY = 200_000_000,
  parameter int T_ON1 = 2000,
  parameter int T_OFF = 500,
  parameter int T_ON2 = 1000
`ifdef DPT_TRIPLE_PULSE_EN
  ,
  parameter int T_ON3 = 500
`endif
) (
  input  logic              clk,
  input  logic              sys_rst_n,
  input  logic              trig_in,
  input  logic [VOLT_W-1:0] volt,
  input  logic              volt_vld,
  input  logic [NCH-1:0]    fault_n,
  input  logic [NCH-1:0]    ch_sel,
  output logic [NCH-1:0]    k_out,
  output logic              busy,
  output logic              done,
  output logic [2:0]        status
);

  localparam int MAX_D0 = (ARM_DLY > T_ON1) ? ARM_DLY : T_ON1;
  localparam int MAX_D1 = (MAX_D0 > T_OFF) ? MAX_D0 : T_OFF;
  localparam int MAX_D2 = (MAX_D1 > T_ON2) ? MAX_D1 : T_ON2;
`ifdef DPT_TRIPLE_PULSE_EN
  localparam int MAX_D = (MAX_D2 > T_ON3) ? MAX_D2 : T_ON3;
`else
  localparam int MAX_D = MAX_D2;
`endif
  localparam int CW = $clog2(MAX_D) + 1;
  localparam int DW = $clog2(DEB_CYC) + 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_PULSE1,
    S_GAP,
    S_PULSE2,
    S_DONE,
    S_ABORT
`ifdef DPT_TRIPLE_PULSE_EN
    , S_GAP2,
    S_PULSE3
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      vcode_q;
  logic            trig_s1_q, trig_s2_q;
  logic [DW-1:0]   deb_cnt_q;
  logic            deb_lvl_q, deb_lvl_prev_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]  sel_q, sel_d;
  logic [NCH-1:0]  k_out_q, k_out_d;
  logic            volt_ok, trig_evt, all_ok, in_seq, pulse_nxt;

  assign volt_ok  = (vcode_q == 2'd1);
  assign trig_evt = deb_lvl_q & ~deb_lvl_prev_q;
  assign all_ok   = &fault_n;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vcode_q <= 2'd0;
    end else if (volt_vld) begin
      if (volt <= V_LO)      vcode_q <= 2'd0;
      else if (volt <= V_HI) vcode_q <= 2'd1;
      else                   vcode_q <= 2'd2;
    end
  end

  // Level only moves after the synced input disagrees with it for DEB_CYC straight cycles.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      trig_s1_q      <= 1'b0;
      trig_s2_q      <= 1'b0;
      deb_cnt_q      <= '0;
      deb_lvl_q      <= 1'b0;
      deb_lvl_prev_q <= 1'b0;
    end else begin
      trig_s1_q      <= trig_in;
      trig_s2_q      <= trig_s1_q;
      deb_lvl_prev_q <= deb_lvl_q;
      if (trig_s2_q != deb_lvl_q) begin
        if (deb_cnt_q == DW'(DEB_CYC - 1)) begin
          deb_lvl_q <= trig_s2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DW'(1);
        end
      end else begin
        deb_cnt_q <= '0;
      end
    end
  end

  function automatic logic [CW-1:0] dur_load(input state_t s);
    case (s)
      S_ARM:    dur_load = CW'(ARM_DLY - 1);
      S_PULSE1: dur_load = CW'(T_ON1 - 1);
      S_GAP:    dur_load = CW'(T_OFF - 1);
      S_PULSE2: dur_load = CW'(T_ON2 - 1);
`ifdef DPT_TRIPLE_PULSE_EN
      S_GAP2:   dur_load = CW'(T_OFF - 1);
      S_PULSE3: dur_load = CW'(T_ON3 - 1);
`endif
      default:  dur_load = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      k_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      k_out_q <= k_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    in_seq  = 1'b0;
    case (state_q)
      S_IDLE:   if (trig_evt && volt_ok && all_ok && (|ch_sel)) state_d = S_ARM;
      S_ARM:    begin in_seq = 1'b1; if (cnt_q == '0) state_d = S_PULSE1; end
      S_PULSE1: begin in_seq = 1'b1; if (cnt_q == '0) state_d = S_GAP; end
      S_GAP:    begin in_seq = 1'b1; if (cnt_q == '0) state_d = S_PULSE2; end
`ifdef DPT_TRIPLE_PULSE_EN
      S_PULSE2: begin in_seq = 1'b1; if (cnt_q == '0) state_d = S_GAP2; end
      S_GAP2:   begin in_seq = 1'b1; if (cnt_q == '0) state_d = S_PULSE3; end
      S_PULSE3: begin in_seq = 1'b1; if (cnt_q == '0) state_d = S_DONE; end
`else
      S_PULSE2: begin in_seq = 1'b1; if (cnt_q == '0) state_d = S_DONE; end
`endif
      S_DONE:   state_d = S_IDLE;
      S_ABORT:  if (!deb_lvl_q && all_ok) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Abort outranks the duration expiry evaluated above.
    if (in_seq && (!all_ok || !volt_ok)) state_d = S_ABORT;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = dur_load(state_d);
    else if (cnt_q != '0)    cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    sel_d = sel_q;
    if (state_q == S_IDLE && state_d == S_ARM) sel_d = ch_sel;
  end

  always_comb begin
`ifdef DPT_TRIPLE_PULSE_EN
    pulse_nxt = (state_d == S_PULSE1) || (state_d == S_PULSE2) || (state_d == S_PULSE3);
`else
    pulse_nxt = (state_d == S_PULSE1) || (state_d == S_PULSE2);
`endif
    k_out_d = pulse_nxt ? (sel_d & fault_n) : '0;
  end

  always_comb begin
    busy   = 1'b0;
    done   = 1'b0;
    status = {1'b0, vcode_q};
    case (state_q)
      S_IDLE:   status = {1'b0, vcode_q};
      S_ARM:    begin busy = 1'b1; status = 3'd3; end
      S_PULSE1, S_GAP, S_PULSE2: begin busy = 1'b1; status = 3'd4; end
`ifdef DPT_TRIPLE_PULSE_EN
      S_GAP2, S_PULSE3: begin busy = 1'b1; status = 3'd4; end
`endif
      S_DONE:   begin done = 1'b1; status = 3'd5; end
      S_ABORT:  status = 3'd6;
      default:  status = 3'd0;
    endcase
  end

  assign k_out = k_out_q;

endmodule

// File: tb/tb_dpt_sequencer.sv
// tb/tb_dpt_sequencer.sv - directed self-checking bench for dpt_sequencer
module tb_dpt_sequencer;

  logic        clk = 1'b0;
  logic        sys_rst_n, trig_in, volt_vld;
  logic [15:0] volt;
  logic [3:0]  fault_n, ch_sel, k_out;
  logic        busy, done;
  logic [2:0]  status;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n;
  logic seen;

  always #5 clk = ~clk;

  dpt_sequencer #(
    .NCH(4), .VOLT_W(16), .V_LO(16'h08B0), .V_HI(16'h0C0C),
    .DEB_CYC(4), .ARM_DLY(100), .T_ON1(20), .T_OFF(5), .T_ON2(10)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .trig_in(trig_in), .volt(volt),
    .volt_vld(volt_vld), .fault_n(fault_n), .ch_sel(ch_sel),
    .k_out(k_out), .busy(busy), .done(done), .status(status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic strobe(input logic [15:0] v);
    volt = v;
    volt_vld = 1'b1;
    @(negedge clk);
    volt_vld = 1'b0;
  endtask

  task automatic wait_status(input string tag, input logic [2:0] s, input int budget);
    int k = 0;
    while (status !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(status), 32'(s));
  endtask

  task automatic idle_cycles(input string tag, input int cycles);
    logic b = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      b |= busy;
    end
    check(tag, 32'(b), 32'd0);
  endtask

  task automatic release_trig;
    trig_in = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    sys_rst_n = 1'b0; trig_in = 1'b0; volt = '0; volt_vld = 1'b0;
    fault_n = 4'hF; ch_sel = 4'b0101;
    repeat (3) @(negedge clk);
    check("rst_k_out", 32'(k_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    sys_rst_n = 1'b1;
    @(negedge clk);

    // Nominal double pulse on channels 0 and 2
    strobe(16'h0A00);
    check("ready_status", 32'(status), 32'd1);
    trig_in = 1'b1;
    wait_status("arm_enter", 3'd3, 50);
    n = 0; seen = 1'b0;
    while (status == 3'd3 && n < 1000) begin seen |= |k_out; n++; @(negedge clk); end
    check("arm_len", 32'(n), 32'd100);
    check("arm_no_pulse", 32'(seen), 32'd0);
    n = 0;
    while (k_out == 4'b0101 && status == 3'd4 && n < 1000) begin n++; @(negedge clk); end
    check("p1_len", 32'(n), 32'd20);
    n = 0;
    while (k_out == 4'b0000 && status == 3'd4 && n < 1000) begin n++; @(negedge clk); end
    check("gap_len", 32'(n), 32'd5);
    n = 0;
    while (k_out == 4'b0101 && status == 3'd4 && n < 1000) begin n++; @(negedge clk); end
    check("p2_len", 32'(n), 32'd10);
    check("done_status", 32'(status), 32'd5);
    check("done_strobe", 32'(done), 32'd1);
    check("done_k_out", 32'(k_out), 32'd0);
    @(negedge clk);
    check("post_done_status", 32'(status), 32'd1);
    check("post_done_strobe", 32'(done), 32'd0);
    release_trig();

    // Out-of-window voltages block arming
    strobe(16'h0800);
    check("undervolt_status", 32'(status), 32'd0);
    trig_in = 1'b1;
    idle_cycles("undervolt_no_arm", 30);
    release_trig();
    strobe(16'h0D00);
    check("overvolt_status", 32'(status), 32'd2);
    trig_in = 1'b1;
    idle_cycles("overvolt_no_arm", 30);
    release_trig();

    // Short glitch never reaches the debounced level
    strobe(16'h0A00);
    trig_in = 1'b1;
    repeat (3) @(negedge clk);
    trig_in = 1'b0;
    idle_cycles("glitch_no_arm", 30);
    check("glitch_status", 32'(status), 32'd1);

    // Fault on channel 3 during cycle 8 of PULSE1
    trig_in = 1'b1;
    wait_status("fault_p1_enter", 3'd4, 200);
    check("fault_p1_k_out", 32'(k_out), 32'h5);
    repeat (7) @(negedge clk);
    fault_n = 4'h7;
    @(negedge clk);
    check("fault_k_out_off", 32'(k_out), 32'd0);
    check("fault_status", 32'(status), 32'd6);
    repeat (5) @(negedge clk);
    check("abort_hold_trig", 32'(status), 32'd6);
    trig_in = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_hold_fault", 32'(status), 32'd6);
    fault_n = 4'hF;
    @(negedge clk);
    check("abort_exit", 32'(status), 32'd1);

    // Upper bound accepted, excursion during ARM aborts, lower bound rejected
    strobe(16'h0C0C);
    check("vhi_accepted", 32'(status), 32'd1);
    trig_in = 1'b1;
    wait_status("vhi_arm", 3'd3, 50);
    repeat (10) @(negedge clk);
    strobe(16'h0C0D);
    wait_status("arm_overvolt_abort", 3'd6, 5);
    check("arm_abort_k_out", 32'(k_out), 32'd0);
    release_trig();
    check("arm_abort_exit", 32'(status), 32'd2);
    strobe(16'h08B0);
    check("vlo_rejected", 32'(status), 32'd0);

    // Retrigger during PULSE2 is ignored
    strobe(16'h0A00);
    trig_in = 1'b1;
    wait_status("rt_arm", 3'd3, 50);
    repeat (20) @(negedge clk);
    trig_in = 1'b0;
    wait_status("rt_p1", 3'd4, 200);
    n = 0;
    while (k_out != 4'b0000 && n < 50) begin n++; @(negedge clk); end
    n = 0;
    while (k_out == 4'b0000 && n < 50) begin n++; @(negedge clk); end
    check("rt_p2_k_out", 32'(k_out), 32'h5);
    trig_in = 1'b1;
    wait_status("rt_done", 3'd5, 50);
    idle_cycles("retrig_ignored", 200);
    release_trig();

    // Reset during GAP
    trig_in = 1'b1;
    wait_status("rg_p1", 3'd4, 200);
    n = 0;
    while (k_out != 4'b0000 && n < 50) begin n++; @(negedge clk); end
    check("rg_gap_status", 32'(status), 32'd4);
    sys_rst_n = 1'b0;
    #1;
    check("rg_k_out", 32'(k_out), 32'd0);
    check("rg_busy", 32'(busy), 32'd0);
    check("rg_done", 32'(done), 32'd0);
    check("rg_status", 32'(status), 32'd0);
    @(negedge clk);
    sys_rst_n = 1'b1;
    @(negedge clk);
    check("rg_vcode_cleared", 32'(status), 32'd0);
    idle_cycles("rg_no_rearm", 20);
    trig_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
